// File: rtl/cnn_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// cnn_scan_ctrl_if
//   OBI-style single-outstanding memory bus between the CNN scan sequencer
//   (master) and the memory fabric (slave).
//
//   mem_req    master->slave  request valid, held until mem_gnt
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  byte address
//   mem_wdata  master->slave  write data
//   mem_be     master->slave  byte enables (4'hF writes, 4'h0 reads)
//   mem_gnt    slave->master  request accepted this cycle
//   mem_rvalid slave->master  response valid (reads and writes)
//   mem_rdata  slave->master  read data
// -----------------------------------------------------------------------------
interface cnn_scan_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cnn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_scan_ctrl
//   Sequencer for the 3x3 conv/ReLU datapath. On start it reads an
//   IMG_H x IMG_W 8-bit image one pixel per bus transaction, pushes each pixel
//   into the line buffer, and once a full KxK window is available writes the
//   ReLU result as a 32-bit word to the output buffer in raster order.
//
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   start_i        one-cycle start pulse (ignored while busy)
//   abort_i        synchronous abort back to IDLE, highest priority
//   input_base_i   byte address of pixel (0,0)
//   output_base_i  byte address of output word (0,0)
//   busy_o         high while a frame is in progress
//   done_o         one-cycle pulse after a complete frame
//   mem            memory bus, master side
//   pix_o          pixel to the line buffer
//   pix_valid_o    one-cycle push strobe to the line buffer
//   conv_i         ReLU result, combinational from the line-buffer window
// -----------------------------------------------------------------------------
module cnn_scan_ctrl #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] input_base_i,
    input  logic [ADDR_WIDTH-1:0] output_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    cnn_scan_ctrl_if.master       mem,
    output logic [7:0]            pix_o,
    output logic                  pix_valid_o,
    input  logic [ACC_WIDTH-1:0]  conv_i
);

    localparam int R_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int C_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int O_N   = (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int O_W   = $clog2(O_N + 1);

    localparam logic [R_W-1:0] R_LAST = R_W'(IMG_H - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(IMG_W - 1);
    localparam logic [R_W-1:0] R_WIN  = R_W'(K - 1);
    localparam logic [C_W-1:0] C_WIN  = C_W'(K - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_PUSH    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_WR_REQ  = 3'd5;
    localparam logic [2:0] S_WR_WAIT = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]            state_q,    state_d;
    logic [R_W-1:0]        r_q,        r_d;
    logic [C_W-1:0]        c_q,        c_d;
    logic [O_W-1:0]        o_q,        o_d;
    logic [ADDR_WIDTH-1:0] in_base_q,  in_base_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
    logic [ACC_WIDTH-1:0]  wdata_q,    wdata_d;
    logic [7:0]            pix_q,      pix_d;
    // Set when an abort leaves a transaction the memory will still answer;
    // new requests are held off until that stale response drains, keeping
    // exactly one transaction outstanding on the bus.
    logic                  drop_q,     drop_d;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            rd_byte;
    logic                  req_state;
    logic                  req_active;
    logic                  advance;

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    assign rd_addr = in_base_q + ADDR_WIDTH'(r_q) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(c_q);
    assign wr_addr = out_base_q + (ADDR_WIDTH'(o_q) << 2);

    // Counters are stable in RD_WAIT, so rd_addr still names the pending read.
    assign rd_byte = mem.mem_rdata[{rd_addr[1:0], 3'b000} +: 8];

    assign req_state  = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign req_active = req_state && !drop_q;

    assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o          = (state_q == S_DONE);
    assign pix_o           = pix_q;
    assign pix_valid_o     = (state_q == S_PUSH);
    assign mem.mem_req     = req_active;
    assign mem.mem_we      = (state_q == S_WR_REQ);
    assign mem.mem_be      = (state_q == S_WR_REQ) ? 4'hF : 4'h0;
    assign mem.mem_wdata   = (state_q == S_WR_REQ) ? 32'(wdata_q) : 32'h0;
    assign mem.mem_addr    = (state_q == S_RD_REQ) ? rd_addr :
                             (state_q == S_WR_REQ) ? wr_addr : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        o_d        = o_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        wdata_d    = wdata_q;
        pix_d      = pix_q;
        drop_d     = drop_q;
        advance    = 1'b0;

        if (drop_q && mem.mem_rvalid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    in_base_d  = input_base_i;
                    out_base_d = output_base_i;
                    r_d        = '0;
                    c_d        = '0;
                    o_d        = '0;
                    state_d    = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (req_active && mem.mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    pix_d   = rd_byte;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Only the counts qualify a window; the line buffer is never
                // cleared, so early outputs would be built from stale rows.
                if (r_q >= R_WIN && c_q >= C_WIN) begin
                    wdata_d = conv_i;
                    state_d = S_WR_REQ;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (req_active && mem.mem_gnt) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem.mem_rvalid) begin
                    o_d     = o_q + O_W'(1);
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                if (r_q == R_LAST) begin
                    state_d = S_DONE;
                end else begin
                    r_d     = r_q + R_W'(1);
                    state_d = S_RD_REQ;
                end
            end else begin
                c_d     = c_q + C_W'(1);
                state_d = S_RD_REQ;
            end
        end

        // Abort overrides every transition above. A grant taken this very
        // cycle, or a response still owed, will be answered by the memory
        // later and must be swallowed.
        if (abort_i) begin
            state_d = S_IDLE;
            if ((req_active && mem.mem_gnt) ||
                (state_q == S_RD_WAIT && !mem.mem_rvalid) ||
                (state_q == S_WR_WAIT && !mem.mem_rvalid)) begin
                drop_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            o_q        <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            wdata_q    <= '0;
            pix_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            o_q        <= o_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            wdata_q    <= wdata_d;
            pix_q      <= pix_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_cnn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnn_scan_ctrl
//   Directed bench for cnn_scan_ctrl. A bus responder returns words whose byte
//   lane k holds ((addr & ~3) + k) & 0xFF, so the selected lane always equals
//   addr & 0xFF while neighbouring lanes differ. conv_i follows the number of
//   pixels pushed so far, which makes each written word identify its window.
// -----------------------------------------------------------------------------
module tb_cnn_scan_ctrl;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;
    localparam int OW    = IMG_W - K + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_base = 32'h1000;
    logic [31:0] out_base = 32'h2000;
    logic        busy, done, pix_valid;
    logic [7:0]  pix;
    logic [31:0] conv = 32'hA500_0000;

    cnn_scan_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    cnn_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_WIDTH(32), .ACC_WIDTH(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .input_base_i (in_base),
        .output_base_i(out_base),
        .busy_o       (busy),
        .done_o       (done),
        .mem          (bus.master),
        .pix_o        (pix),
        .pix_valid_o  (pix_valid),
        .conv_i       (conv)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder / monitor controls and log.
    bit          stall_en = 0, gnt_block = 0, rvalid_block = 0, conv_force = 0;
    logic [31:0] exp_in_base = 32'h1000, exp_out_base = 32'h2000;
    int          rd_cnt, wr_cnt, push_cnt, done_cnt;
    int          rd_err, wr_err, pix_err, stab_err;
    logic [31:0] rd_addr_log [2];
    logic [7:0]  pix_log [2];
    logic [31:0] first_wr_addr, last_wr_addr, last_wr_data, first_wr_prev_rd, last_rd_addr;
    bit          pend;
    int          dly, gwait;
    logic        req_s, we_s;
    logic [31:0] addr_s, wdata_s;
    logic [3:0]  be_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic int win_idx(input int n);
        return (n / OW + K - 1) * IMG_W + (n % OW) + K - 1;
    endfunction

    task automatic clear_log();
        rd_cnt = 0; wr_cnt = 0; push_cnt = 0; done_cnt = 0;
        rd_err = 0; wr_err = 0; pix_err = 0; stab_err = 0;
        rd_addr_log[0] = '0; rd_addr_log[1] = '0;
        pix_log[0] = '0; pix_log[1] = '0;
        first_wr_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        first_wr_prev_rd = '0; last_rd_addr = '0;
        pend = 0; dly = 0; gwait = 0;
        bus.mem_rvalid = 1'b0;
        conv = conv_force ? 32'hDEAD_BEEF : 32'hA500_0000;
    endtask

    // Bus responder and monitor: decides gnt/rvalid for the next rising edge
    // from what happened at the previous one.
    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        req_s = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0; be_s = '0;
        clear_log();
        forever begin
            @(negedge clk);
            if (bus.mem_rvalid) pend = 0;
            if (bus.mem_gnt && req_s) begin
                if (!we_s) begin
                    if (addr_s !== exp_in_base + 32'(rd_cnt) || be_s !== 4'h0) rd_err++;
                    if (rd_cnt < 2) rd_addr_log[rd_cnt] = addr_s;
                    last_rd_addr = addr_s;
                    rd_cnt++;
                end else begin
                    int idx;
                    logic [31:0] exp_d;
                    idx   = win_idx(wr_cnt);
                    exp_d = conv_force ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(idx + 1));
                    if (addr_s !== exp_out_base + 32'(4 * wr_cnt) || wdata_s !== exp_d ||
                        be_s !== 4'hF || rd_cnt != idx + 1) wr_err++;
                    if (wr_cnt == 0) begin
                        first_wr_addr    = addr_s;
                        first_wr_prev_rd = last_rd_addr;
                    end
                    last_wr_addr = addr_s;
                    last_wr_data = wdata_s;
                    wr_cnt++;
                end
                pend  = 1;
                dly   = stall_en ? int'($urandom_range(0, 5)) : 0;
                gwait = stall_en ? int'($urandom_range(0, 5)) : 0;
            end else if (req_s && bus.mem_req) begin
                if (bus.mem_addr !== addr_s || bus.mem_we !== we_s ||
                    bus.mem_wdata !== wdata_s || bus.mem_be !== be_s) stab_err++;
            end
            req_s = bus.mem_req; we_s = bus.mem_we; addr_s = bus.mem_addr;
            wdata_s = bus.mem_wdata; be_s = bus.mem_be;
            if (pix_valid) begin
                if (pix !== last_rd_addr[7:0]) pix_err++;
                if (push_cnt < 2) pix_log[push_cnt] = pix;
                push_cnt++;
                conv = conv_force ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(push_cnt));
            end
            if (done) done_cnt++;
            if (pend && !rvalid_block && dly == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word(addr_s_of_pend());
            end else begin
                if (pend && !rvalid_block) dly--;
                bus.mem_rvalid = 1'b0;
            end
            if (gnt_block && req_s && we_s) begin
                bus.mem_gnt = 1'b0;
            end else if (gwait > 0) begin
                bus.mem_gnt = 1'b0;
                if (req_s) gwait--;
            end else begin
                bus.mem_gnt = 1'b1;
            end
        end
    end

    // The only transaction that can be pending is the latest granted one;
    // writes return don't-care data, so the last read address is enough.
    function automatic logic [31:0] addr_s_of_pend();
        return last_rd_addr;
    endfunction

    task automatic frame_checks(input string p, input logic [31:0] last_data);
        check({p, "_reads"},             32'(rd_cnt), 32'd784);
        check({p, "_writes"},            32'(wr_cnt), 32'd676);
        check({p, "_first_wr_addr"},     first_wr_addr, 32'h2000);
        check({p, "_rd_before_first_wr"}, first_wr_prev_rd, 32'h103A);
        check({p, "_last_wr_addr"},      last_wr_addr, 32'h2A8C);
        check({p, "_last_wr_data"},      last_wr_data, last_data);
        check({p, "_rd_seq_errors"},     32'(rd_err), 32'd0);
        check({p, "_wr_seq_errors"},     32'(wr_err), 32'd0);
        check({p, "_pix_errors"},        32'(pix_err), 32'd0);
        check({p, "_stable_errors"},     32'(stab_err), 32'd0);
    endtask

    task automatic wait_frame(input string p, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check({p, "_done_in_time"}, 32'(done_cnt), 32'd1);
        check({p, "_busy_low_in_done"}, busy, 1'b0);
        step();
        check({p, "_done_single_cycle"}, 32'(done_cnt), 32'd1);
        check({p, "_busy_low_after"}, busy, 1'b0);
    endtask

    initial begin
        int n;

        // Reset state.
        step(2);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", bus.mem_req, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_be", bus.mem_be, 4'h0);
        check("rst_pix", pix, 8'h0);
        check("rst_pix_valid", pix_valid, 1'b0);
        rst = 1'b0;
        step();

        // Frame A: no stalls, with a second start pulse mid-frame.
        clear_log();
        start = 1'b1; step(); start = 1'b0;
        check("a_busy_after_start", busy, 1'b1);
        step(400);
        in_base = 32'h5000; out_base = 32'h6000;
        start = 1'b1; step(); start = 1'b0;
        in_base = 32'h1000; out_base = 32'h2000;
        check("a_busy_after_restart", busy, 1'b1);
        wait_frame("a", 20000);
        frame_checks("a", 32'hA500_0310);

        // Frame B: random grant/response stalls, conv forced.
        stall_en = 1; conv_force = 1;
        clear_log();
        start = 1'b1; step(); start = 1'b0;
        wait_frame("b", 60000);
        frame_checks("b", 32'hDEAD_BEEF);
        stall_en = 0; conv_force = 0;

        // Byte lanes, then abort while a write waits for grant.
        in_base = 32'h1003; exp_in_base = 32'h1003; gnt_block = 1;
        clear_log();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (push_cnt < 2 && n < 200) begin step(); n++; end
        check("lane_first_addr", rd_addr_log[0], 32'h1003);
        check("lane_first_pix", pix_log[0], 8'h03);
        check("lane_second_addr", rd_addr_log[1], 32'h1004);
        check("lane_second_pix", pix_log[1], 8'h04);
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 2000) begin step(); n++; end
        check("wr_req_reached", bus.mem_req && bus.mem_we, 1'b1);
        check("wr_req_reads_before", 32'(rd_cnt), 32'd59);
        check("wr_req_addr", bus.mem_addr, 32'h2000);
        step(3);
        check("wr_req_held_addr", bus.mem_addr, 32'h2000);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_req_dropped", bus.mem_req, 1'b0);
        check("abort_busy_low", busy, 1'b0);
        step(5);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_write", 32'(wr_cnt), 32'd0);
        check("abort_stable_errors", 32'(stab_err), 32'd0);
        gnt_block = 0;

        // Asynchronous reset while waiting for a read response.
        in_base = 32'h1000; exp_in_base = 32'h1000;
        clear_log();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (push_cnt < 5 && n < 200) begin step(); n++; end
        rvalid_block = 1;
        n = 0;
        while (rd_cnt < 6 && n < 50) begin step(); n++; end
        step(2);
        check("pre_rst_pix", pix, 8'h04);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_req", bus.mem_req, 1'b0);
        check("async_rst_pix", pix, 8'h00);
        check("async_rst_addr", bus.mem_addr, 32'h0);
        step(2);
        rst = 1'b0; rvalid_block = 0;
        clear_log();
        step();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (rd_cnt < 1 && n < 50) begin step(); n++; end
        check("post_rst_first_addr", rd_addr_log[0], 32'h1000);
        wait_frame("c", 20000);
        frame_checks("c", 32'hA500_0310);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
